// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and transmitter's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 busy;
  logic [2:0]           owner;

  modport master (
    output req, data_in,
    input  grant, tx_data, tx_start, busy, owner
  );

  modport slave (
    input  req, data_in,
    output grant, tx_data, tx_start, busy, owner
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_FIXED_PRIO_EN to select lowest-index fixed priority instead.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 11,
  parameter int GAP_CYCLES   = 0
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]         state, state_nx;
  logic [3:0]         frame_cnt, gap_cnt;
  logic [NUM_REQ-1:0] grant_q, grant_nx;
  logic [7:0]         tx_data_q;
  logic               tx_start_q, busy_q;
  logic [2:0]         owner_q;

  // Pad to 8 entries so a 3-bit index is always in range.
  logic [7:0] req_pad;
  logic [7:0] bytes [8];
  assign req_pad = 8'(bus.req);

  for (genvar i = 0; i < 8; i++) begin : g_bytes
    if (i < NUM_REQ) begin : g_live
      assign bytes[i] = bus.data_in[8*i +: 8];
    end else begin : g_pad
      assign bytes[i] = 8'h00;
    end
  end

  logic [2:0] winner, idx;
  logic       found;

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = owner_q;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 3'(k);
      if (!found && req_pad[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  // Search starts just after the last owner and wraps over existing indices only.
  always_comb begin
    winner = owner_q;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 3'((int'(owner_q) + k) % NUM_REQ);
      if (!found && req_pad[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) grant_nx[i] = (winner == 3'(i));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|bus.req) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SEND;
      S_SEND:  if (frame_cnt == 4'd1) state_nx = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == 4'd1) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_cnt  <= '0;
      gap_cnt    <= '0;
      grant_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= 3'(NUM_REQ - 1);
    end else begin
      state      <= state_nx;
      busy_q     <= (state_nx != S_IDLE);
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      case (state)
        S_IDLE: if (|bus.req) begin
          owner_q    <= winner;
          tx_data_q  <= bytes[winner];
          grant_q    <= grant_nx;
          tx_start_q <= 1'b1;
        end
        S_LOAD: frame_cnt <= 4'(FRAME_CYCLES - 1);
        S_SEND: begin
          frame_cnt <= frame_cnt - 4'd1;
          if (frame_cnt == 4'd1 && GAP_CYCLES > 0) gap_cnt <= 4'(GAP_CYCLES);
        end
        S_GAP:   gap_cnt <= gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance without gap, one with a 3-cycle gap.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) ifa ();
  uart_tx_arbiter_if #(.NUM_REQ(4)) ifb ();

  uart_tx_arbiter #(.NUM_REQ(4), .FRAME_CYCLES(11), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  uart_tx_arbiter #(.NUM_REQ(4), .FRAME_CYCLES(11), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifa.req = '0;
    ifb.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Advance to the next tx_start of instance a (sel=0) or b (sel=1), bounded.
  task automatic wait_start(input bit sel, output int t);
    for (int i = 0; i < 60 && !(sel ? ifb.tx_start : ifa.tx_start); i++) tick();
    chk(sel ? "start_b_seen" : "start_a_seen", sel ? ifb.tx_start : ifa.tx_start, 1);
    t = cyc;
  endtask

  initial begin
    int t, prev, nb, bad;
    ifa.data_in = '0;
    ifb.data_in = '0;

    // Reset values and single request
    do_reset();
    chk("rst_busy", ifa.busy, 0);
    chk("rst_grant", ifa.grant, 0);
    chk("rst_tx_start", ifa.tx_start, 0);
    chk("rst_tx_data", ifa.tx_data, 8'h00);
    chk("rst_owner", ifa.owner, 3);
    ifa.req = 4'b0001;
    ifa.data_in = 32'h0000_00A5;
    tick();
    chk("t1_grant", ifa.grant, 4'b0001);
    chk("t1_tx_start", ifa.tx_start, 1);
    chk("t1_tx_data", ifa.tx_data, 8'hA5);
    ifa.req = '0;
    nb = 1;
    tick();
    chk("t1_grant_pulse", ifa.grant, 0);
    chk("t1_start_pulse", ifa.tx_start, 0);
    while (ifa.busy && nb < 40) begin
      nb++;
      tick();
    end
    chk("t1_busy_len", nb, 11);
    chk("t1_owner", ifa.owner, 0);

    // All four requesting: rotation and frame period
    do_reset();
    ifa.req = 4'b1111;
    ifa.data_in = 32'h4332_2110;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start(0, t);
      chk("t2_grant", ifa.grant, 32'(1) << (k % 4));
      chk("t2_tx_data", ifa.tx_data, 8'h10 + 8'h11 * (k % 4));
      if (k > 0) chk("t2_period", t - prev, 12);
      prev = t;
      tick();
    end
    ifa.req = '0;

    // Gap instance, single requester held high
    do_reset();
    ifb.req = 4'b0100;
    ifb.data_in = 32'h0077_0000;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_start(1, t);
      chk("t3_grant", ifb.grant, 4'b0100);
      chk("t3_tx_data", ifb.tx_data, 8'h77);
      if (k > 0) chk("t3_period", t - prev, 15);
      prev = t;
      nb = 0;
      bad = 0;
      while (ifb.busy && nb < 40) begin
        if (ifb.tx_data !== 8'h77) bad++;
        nb++;
        tick();
      end
      chk("t3_busy_len", nb, 14);
      chk("t3_stable", bad, 0);
    end
    ifb.req = '0;

    // Data changed mid-frame must not reach tx_data
    do_reset();
    ifa.req = 4'b0001;
    ifa.data_in = 32'h0000_0055;
    wait_start(0, t);
    chk("t4_tx_data", ifa.tx_data, 8'h55);
    ifa.req = '0;
    tick(); tick(); tick();
    ifa.data_in = 32'h0000_00AA;
    bad = 0;
    nb = 0;
    while (ifa.busy && nb < 40) begin
      if (ifa.tx_data !== 8'h55) bad++;
      nb++;
      tick();
    end
    chk("t4_stable", bad, 0);
    chk("t4_hold_idle", ifa.tx_data, 8'h55);
    ifa.req = 4'b0001;
    wait_start(0, t);
    chk("t4_new_data", ifa.tx_data, 8'hAA);
    ifa.req = '0;

    // Reset in SEND cycle 5
    do_reset();
    ifa.req = 4'b0001;
    ifa.data_in = 32'h0000_0033;
    wait_start(0, t);
    ifa.req = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_pre_busy", ifa.busy, 1);
    rst = 1'b1;
    tick();
    chk("t5_busy", ifa.busy, 0);
    chk("t5_tx_start", ifa.tx_start, 0);
    chk("t5_tx_data", ifa.tx_data, 8'h00);
    chk("t5_owner", ifa.owner, 3);
    rst = 1'b0;
    ifa.req = 4'b0010;
    tick();
    chk("t5_grant", ifa.grant, 4'b0010);
    chk("t5_start", ifa.tx_start, 1);
    chk("t5_owner_new", ifa.owner, 1);
    ifa.req = '0;

    // Two requesters held: fixed priority favours 1, round-robin alternates
    do_reset();
    ifa.req = 4'b1010;
    ifa.data_in = 32'hD300_C100;
    for (int k = 0; k < 4; k++) begin
      wait_start(0, t);
`ifdef UART_ARB_FIXED_PRIO_EN
      chk("t6_grant", ifa.grant, 4'b0010);
      chk("t6_tx_data", ifa.tx_data, 8'hC1);
`else
      chk("t6_grant", ifa.grant, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      chk("t6_tx_data", ifa.tx_data, (k % 2 == 0) ? 8'hC1 : 8'hD3);
`endif
      tick();
    end
    ifa.req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte requesters.
- Round-robin arbitration. Latches the winner's byte and issues a one-cycle start pulse to the transmitter.
- Times the frame with an internal counter and inserts an optional idle gap before the next arbitration.
- Sits between on-chip byte sources (keyboard scanner, status reporter, echo path) and the transmitter's data/start inputs.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- FRAME_CYCLES, 11: clocks the transmitter needs per frame (start + 8 data + stop + turnaround), >= 2.
- GAP_CYCLES, 0: idle clocks inserted after each frame, 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester "byte pending"; level, held until granted.
- data_in  in  8*NUM_REQ  requester bytes; requester i at [8i+7:8i].
- grant  out  NUM_REQ  one-hot, one-cycle pulse; byte of that requester accepted.
- tx_data  out  8  byte to transmitter; stable from tx_start through end of SEND.
- tx_start  out  1  one-cycle start pulse to transmitter.
- busy  out  1  high in any state other than IDLE.
- owner  out  3  index of current/last granted requester.

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst.
- Reset values: state IDLE, grant=0, tx_data=8'h00, tx_start=0, busy=0, owner=NUM_REQ-1 (so requester 0 wins first), counters 0.
- All outputs are registered.
- States:
  - IDLE: if req!=0, pick a winner and go to LOAD; else stay.
  - LOAD: one cycle; go to SEND.
  - SEND: FRAME_CYCLES-1 cycles; go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: GAP_CYCLES cycles; go to IDLE.
- Arbitration (IDLE, req!=0): search owner+1, owner+2, ... modulo NUM_REQ. First asserted req wins.
- Winner update on the IDLE->LOAD edge:
  - owner <= winner.
  - tx_data <= data_in[winner].
  - grant[winner] <= 1.
  - tx_start <= 1.
- Cycle relationship: grant and tx_start are high together during the LOAD cycle, exactly one cycle each.
- Latency: req sampled high in IDLE at edge t -> grant/tx_start high in cycle t+1.
- Requester must drop or update req/data on the cycle after grant. If req is still high in the next IDLE, it is treated as a new byte.
- Frame period: LOAD to next possible LOAD = FRAME_CYCLES + GAP_CYCLES + 1 cycles (the +1 is the IDLE arbitration cycle).
- Frame counter: 4 bits, loaded in LOAD, decremented in SEND, exit at 1. Gap counter works the same way.
- tx_data holds its value outside LOAD. It is never changed mid-frame.
- req changes during LOAD/SEND/GAP are ignored until IDLE.
- A requester whose req drops before it is granted loses nothing; it is simply not selected.
- Simultaneous requests: exactly one grant per frame. With all req high, grants rotate 0,1,2,3,0,...
- Single requester with req held high: granted every frame period (no starvation, no extra gap).
- Reset mid-frame: return to IDLE next cycle, all outputs to reset values. The partial frame is abandoned; the transmitter sees no further start.
- NUM_REQ not a power of two: the modulo wrap skips non-existent indices.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index wins. owner is still updated but not used for selection.
- Undefined: round-robin as above.
- All timing is identical in both modes.

Test Plan:
- Reset, then req=4'b0001, data_in[7:0]=8'hA5: grant=4'b0001 and tx_start=1 in the same single cycle, tx_data=8'hA5, busy high 11 cycles, back to IDLE; owner=0.
- req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43: grants in order 0,1,2,3,0. tx_start pulses exactly 12 cycles apart (FRAME_CYCLES=11, GAP_CYCLES=0).
- GAP_CYCLES=3, req=4'b0100 held: tx_start spacing 15 cycles; tx_data=data_in[23:16] stable across each whole SEND.
- Change data_in[7:0] from 8'h55 to 8'hAA mid-SEND: tx_data stays 8'h55 until the next LOAD.
- Assert rst for one cycle at SEND cycle 5: next cycle busy=0, tx_start=0, tx_data=8'h00. After rst release with req=4'b0010, requester 1 is granted one cycle later.
- With UART_ARB_FIXED_PRIO_EN and req=4'b1010 held: requester 1 granted every frame, requester 3 never granted.
